// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues one-word ROM reads and buffers {pc, instr} for decode.
// Optional combinational empty-queue bypass of the ROM response is enabled by defining IFQ_BYPASS_EN.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          IMEM_AW  = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_instr,
  output logic               misalign_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  ifq_entry_t    mem [DEPTH];
  ifq_entry_t    resp, head;
  logic [31:0]   fetch_pc, tag;
  logic          inflight, squash;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          resp_vld, empty, bypass, push, pop;

  assign resp      = '{pc: tag, instr: imem_rdata};
  assign resp_vld  = inflight && !squash;
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  // Credit: queued entries plus the one in flight may never exceed DEPTH.
  assign occ       = {1'b0, count} + (CW+1)'(inflight);
  assign imem_req  = !reset && !redirect && (occ < DEPTH_C);
  assign imem_addr = fetch_pc[IMEM_AW+1:2];

`ifdef IFQ_BYPASS_EN
  assign bypass = empty && resp_vld;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed response taken by decode in the same cycle never enters the FIFO.
  assign push = resp_vld && !(bypass && out_ready);
  assign pop  = !empty && out_ready;

  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_instr = '0;
    if (!empty) begin
      out_valid = 1'b1;
      out_pc    = head.pc;
      out_instr = head.instr;
    end else if (bypass) begin
      out_valid = 1'b1;
      out_pc    = resp.pc;
      out_instr = resp.instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      tag          <= '0;
      inflight     <= 1'b0;
      squash       <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
    end else if (redirect) begin
      // Flush everything; a pop presented this cycle is dropped along with the queue.
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      squash   <= 1'b1;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
    end else begin
      squash   <= 1'b0;
      inflight <= imem_req;
      if (imem_req) begin
        tag      <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !redirect && push) mem[wr_ptr] <= resp;
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (default build): per-cycle vector table plus fill/stream sequences.
module tb_ifetch_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_instr;
  logic        misalign_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  ifetch_queue #(.DEPTH(4), .IMEM_AW(6), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // ROM[i] = i + 0x100, one-cycle read latency
  always_ff @(posedge clk) imem_rdata <= 32'h100 + 32'(imem_addr);

  typedef struct {
    bit          chk;
    bit          rst;
    bit          rd;
    logic [31:0] rpc;
    bit          rdy;
    bit          e_req;
    int          e_addr;
    bit          e_vld;
    logic [31:0] e_pc;
    bit          e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit chk, input bit rst, input bit rd, input logic [31:0] rpc,
                     input bit rdy, input bit e_req, input int e_addr, input bit e_vld,
                     input logic [31:0] e_pc, input bit e_mis);
    vec_t v;
    v.chk = chk; v.rst = rst; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc; v.e_mis = e_mis;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] rom_of(input logic [31:0] pc);
    return 32'h100 + {26'd0, pc[7:2]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int issues, cyc;
    logic [31:0] exp_pc;

    //   chk rst rd rpc           rdy req addr vld pc            mis
    // fill with out_ready=0, then redirect+pop at count=3 to a misaligned target
    add(0, 1, 0, 32'h0,        0,  0,  0,   0,  32'h0,        0);
    add(1, 1, 0, 32'h0,        0,  0,  0,   0,  32'h0,        0);
    add(1, 0, 0, 32'h0,        0,  1,  0,   0,  32'h0,        0);
    add(1, 0, 0, 32'h0,        0,  1,  1,   0,  32'h0,        0);
    add(1, 0, 0, 32'h0,        0,  1,  2,   1,  32'h0,        0);
    add(1, 0, 0, 32'h0,        0,  1,  3,   1,  32'h0,        0);
    add(1, 0, 0, 32'h0,        0,  0,  0,   1,  32'h0,        0);
    add(1, 0, 0, 32'h0,        0,  0,  0,   1,  32'h0,        0);
    add(1, 0, 0, 32'h0,        1,  0,  0,   1,  32'h0,        0);
    add(1, 0, 1, 32'h1E,       1,  0,  0,   1,  32'h4,        0);
    add(1, 0, 0, 32'h0,        1,  1,  7,   0,  32'h0,        1);
    add(1, 0, 0, 32'h0,        1,  1,  8,   0,  32'h0,        1);
    add(1, 0, 0, 32'h0,        1,  1,  9,   1,  32'h1C,       1);
    add(1, 0, 0, 32'h0,        0,  1,  10,  1,  32'h20,       1);
    // reset mid-stream with count=2, inflight=1
    add(1, 1, 0, 32'h0,        0,  0,  0,   1,  32'h20,       1);
    add(1, 0, 0, 32'h0,        0,  1,  0,   0,  32'h0,        0);
    add(1, 0, 0, 32'h0,        0,  1,  1,   0,  32'h0,        0);
    add(1, 0, 0, 32'h0,        1,  1,  2,   1,  32'h0,        0);
    // redirect to top of address space: ROM index 63 then wrap to 0
    add(1, 0, 1, 32'hFFFFFFFC, 1,  0,  0,   1,  32'h4,        0);
    add(1, 0, 0, 32'h0,        1,  1,  63,  0,  32'h0,        0);
    add(1, 0, 0, 32'h0,        1,  1,  0,   0,  32'h0,        0);
    add(1, 0, 0, 32'h0,        1,  1,  1,   1,  32'hFFFFFFFC, 0);
    add(1, 0, 0, 32'h0,        1,  1,  2,   1,  32'h0,        0);
    // stream with redirect while the 0x8 fetch is in flight
    add(0, 1, 0, 32'h0,        1,  0,  0,   0,  32'h0,        0);
    add(1, 1, 0, 32'h0,        1,  0,  0,   0,  32'h0,        0);
    add(1, 0, 0, 32'h0,        1,  1,  0,   0,  32'h0,        0);
    add(1, 0, 0, 32'h0,        1,  1,  1,   0,  32'h0,        0);
    add(1, 0, 0, 32'h0,        1,  1,  2,   1,  32'h0,        0);
    add(1, 0, 1, 32'h20,       1,  0,  0,   1,  32'h4,        0);
    add(1, 0, 0, 32'h0,        1,  1,  8,   0,  32'h0,        0);
    add(1, 0, 0, 32'h0,        1,  1,  9,   0,  32'h0,        0);
    add(1, 0, 0, 32'h0,        1,  1,  10,  1,  32'h20,       0);
    add(1, 0, 0, 32'h0,        1,  1,  11,  1,  32'h24,       0);
    add(1, 0, 0, 32'h0,        1,  1,  12,  1,  32'h28,       0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset       = vecs[i].rst;
      redirect    = vecs[i].rd;
      redirect_pc = vecs[i].rpc;
      out_ready   = vecs[i].rdy;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("row%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
        if (vecs[i].e_req)
          check($sformatf("row%0d_addr", i), {26'd0, imem_addr}, 32'(vecs[i].e_addr));
        check($sformatf("row%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_vld});
        check($sformatf("row%0d_misalign", i), {31'd0, misalign_err}, {31'd0, vecs[i].e_mis});
        if (vecs[i].e_vld) begin
          check($sformatf("row%0d_pc", i), out_pc, vecs[i].e_pc);
          check($sformatf("row%0d_instr", i), out_instr, rom_of(vecs[i].e_pc));
        end else if (vecs[i].rst) begin
          check($sformatf("row%0d_reset_pc", i), out_pc, 32'h0);
          check($sformatf("row%0d_reset_instr", i), out_instr, 32'h0);
        end
      end
    end

    // fill: exactly DEPTH issues before the credit rule stops fetching
    @(negedge clk); reset = 1'b1; redirect = 1'b0; out_ready = 1'b0;
    @(negedge clk); reset = 1'b0;
    issues = 0; cyc = 0;
    #1;
    while (imem_req && cyc < 20) begin
      issues++;
      @(negedge clk); #1;
      cyc++;
    end
    check("fill_issue_count", 32'(issues), 32'd4);
    repeat (2) @(negedge clk);
    #1;
    check("fill_req_low", {31'd0, imem_req}, 32'd0);
    check("fill_valid", {31'd0, out_valid}, 32'd1);
    check("fill_head_pc", out_pc, 32'h0);
    check("fill_head_instr", out_instr, 32'h100);

    // stream: first valid two cycles after reset release, then one per cycle
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; out_ready = 1'b1;
    cyc = 0;
    #1;
    while (!out_valid && cyc < 10) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("stream_first_valid_cycle", 32'(cyc), 32'd2);
    for (int k = 0; k < 6; k++) begin
      exp_pc = 32'(k * 4);
      check($sformatf("stream%0d_valid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("stream%0d_pc", k), out_pc, exp_pc);
      check($sformatf("stream%0d_instr", k), out_instr, rom_of(exp_pc));
      @(negedge clk); #1;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
